shift_issue: RTL
================

# shift_issue

Registered issue stage directly upstream of the combinational barrel shifter in the RV32I execute path. It decodes RV32I shift instructions (SLL/SRL/SRA and the SLLI/SRLI/SRAI immediate forms) into the shifter's 2-bit control code and 5-bit shift amount, and registers the operand. A valid/ready interface with a 2-entry skid buffer gives full throughput under downstream backpressure. It also flags illegal encodings and counts them.

## Interface
- WIDTH, 32: operand and result data width.
- CNT_W, 16: width of the illegal-encoding counter.
- clk  in  1: single clock; all state updates on the rising edge.
- rst_n  in  1: reset, asynchronous assert, active-low; no synchronous reset path.
- flush  in  1: synchronous pipeline flush; drops all held entries.
- in_valid  in  1: upstream offers an instruction.
- in_ready  out  1: stage can accept; registered, not combinationally dependent on out_ready.
- funct3  in  3: instruction funct3.
- funct7  in  7: instruction funct7; used for the register form only.
- is_imm  in  1: 1 selects the immediate form (OP-IMM), 0 selects the register form (OP).
- imm  in  12: I-type immediate; imm[4:0] is shamt and imm[11:5] is the funct7 field.
- rs1_data  in  WIDTH: operand to shift.
- rs2_data  in  WIDTH: register-form shift source; only bits [4:0] are used.
- rd  in  5: destination register tag, carried through unchanged.
- out_valid  out  1: shifter inputs are valid.
- out_ready  in  1: downstream consumes.
- out_control  out  2: shifter control; 00 LSL, 01 LSR, 10 rotate-right, 11 ASR.
- out_shamt  out  5: shift amount.
- out_data  out  WIDTH: operand (rs1_data, registered).
- out_rd  out  5: destination tag.
- out_illegal  out  1: entry had an unsupported encoding.
- illegal_count  out  CNT_W: saturating count of illegal entries accepted.

## Operation
- **Decode.** Decode uses f7 = is_imm ? imm[11:5] : funct7 and sh = is_imm ? imm[4:0] : rs2_data[4:0].
  - funct3=001, f7=0000000: LSL (00).
  - funct3=101, f7=0000000: LSR (01).
  - funct3=101, f7=0100000: ASR (11).
  - funct3=101, f7=0110000: rotate-right (10), only when rotate is compiled in (see Configuration).
- **Illegal encodings.** Any other combination sets out_illegal=1 and forces out_control=00 and out_shamt=0; out_data and out_rd still pass through unchanged.
- **Accept.** An entry is accepted when in_valid && in_ready; decode happens on accept.
- **Storage.** The stage holds two entries:
  - OUT: drives the outputs.
  - SKID: holds the overflow entry.
- **State machine.** States are EMPTY (no entries), ONE (OUT valid, SKID empty) and FULL (both valid).
  - EMPTY, accept: go to ONE.
  - ONE, accept without downstream take: go to FULL (new entry into SKID).
  - ONE, accept with take: stay in ONE (new entry replaces OUT).
  - ONE, take without accept: go to EMPTY.
  - FULL, take: SKID moves into OUT; go to ONE.
  - FULL, no take: hold.
- **Outputs.** in_ready = (state != FULL). out_valid = (state != EMPTY).
- **Ordering.** Order is strictly FIFO; entries are never dropped except by flush.
- **Flush.**
  - Next state is EMPTY, overriding any accept or take in the same cycle.
  - An entry accepted in the flush cycle is discarded and is not counted.
- **illegal_count.**
  - Increments by 1 for each accepted illegal entry.
  - Saturates at all-ones and does not wrap.
  - Cleared only by reset; flush does not clear it.

## Timing
- **Latency.** An entry accepted at edge N is on the outputs with out_valid=1 after edge N. The latency is 1 cycle.
- **Throughput.** One instruction per cycle while out_ready=1.
- **Stall behaviour.** While out_valid && !out_ready, all out_* signals hold stable.
- **in_ready response.** in_ready falls the cycle after SKID fills and rises the cycle after SKID drains.
- **Reset values.**
  - Control outputs: out_valid=0, in_ready=1, out_illegal=0.
  - Data outputs: out_control=00, out_shamt=0, out_data=0, out_rd=0.
  - Counter: illegal_count=0.
- **Reset mid-operation.** Asserting rst_n low discards all entries immediately (asynchronous). The first accept is possible on the first edge after deassertion.

## Configuration
- **SHIFT_ROTATE_EN defined:** funct3=101 with f7=0110000 decodes to control 10 with normal shamt.
- **SHIFT_ROTATE_EN undefined:** that encoding is illegal (out_illegal=1, control 00, shamt 0, counted), and control 10 is never produced.

## Test plan
- **Reset:** rst_n low mid-stream with both entries held -> out_valid=0, in_ready=1, illegal_count=0 immediately, before the next clock edge.
- **Immediate decode:** is_imm=1, funct3=101, imm=0x403, rs1_data=0x80000000, rd=7 -> one cycle later out_control=11, out_shamt=3, out_data=0x80000000, out_rd=7, out_illegal=0.
- **Register decode:** is_imm=0, funct3=001, funct7=0, rs2_data=0xFFFFFF25 -> out_control=00, out_shamt=5.
- **Backpressure:** hold out_ready=0 and offer entries A, B, C back-to-back -> A on outputs, B in SKID, in_ready=0 and C not accepted. Then raise out_ready -> A, B, C emerge in order on consecutive cycles with no loss.
- **Illegal plus flush:** illegal funct3=000 -> out_illegal=1, control 00, count 1. Flush asserted with in_valid=1 and state FULL -> state EMPTY next cycle, count unchanged.
- **Rotate and saturation:** f7=0110000, funct3=101, shamt=8 -> control 10 when SHIFT_ROTATE_EN is defined, illegal otherwise. Counter preloaded to 0xFFFF plus one more illegal entry -> stays 0xFFFF.

Source files
------------

// File: rtl/shift_issue.sv
// Registered issue stage feeding the RV32I barrel shifter: decodes shift instructions, buffers them in a
// 2-entry skid buffer and counts illegal encodings. Define SHIFT_ROTATE_EN to decode the rotate-right encoding.
module shift_issue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             is_imm,
  input  logic [11:0]      imm,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [4:0]       rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_control,
  output logic [4:0]       out_shamt,
  output logic [WIDTH-1:0] out_data,
  output logic [4:0]       out_rd,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  typedef struct packed {
    logic [1:0]       control;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] data;
    logic [4:0]       rd;
    logic             illegal;
  } entry_t;

  state_t           state, state_nxt;
  entry_t           out_q, skid_q, dec;
  logic             in_ready_q, out_valid_q;
  logic [CNT_W-1:0] count_q;
  logic [6:0]       f7;
  logic [4:0]       sh;
  logic             acc, take, load_out, load_skid, skid_to_out;
  logic             unused_rs2;

  assign unused_rs2 = ^rs2_data[WIDTH-1:5];

  assign acc  = in_valid && in_ready_q;
  assign take = out_valid_q && out_ready;

  // Shift decode; anything unrecognised becomes an illegal no-op shift.
  always_comb begin
    f7          = is_imm ? imm[11:5] : funct7;
    sh          = is_imm ? imm[4:0] : rs2_data[4:0];
    dec         = '0;
    dec.data    = rs1_data;
    dec.rd      = rd;
    dec.illegal = 1'b1;
    if (funct3 == 3'b001 && f7 == 7'b0000000) begin
      dec.control = 2'b00;
      dec.shamt   = sh;
      dec.illegal = 1'b0;
    end else if (funct3 == 3'b101) begin
      if (f7 == 7'b0000000) begin
        dec.control = 2'b01;
        dec.shamt   = sh;
        dec.illegal = 1'b0;
      end else if (f7 == 7'b0100000) begin
        dec.control = 2'b11;
        dec.shamt   = sh;
        dec.illegal = 1'b0;
      end
`ifdef SHIFT_ROTATE_EN
      else if (f7 == 7'b0110000) begin
        dec.control = 2'b10;
        dec.shamt   = sh;
        dec.illegal = 1'b0;
      end
`else
`endif
    end
  end

  // Next-state and buffer-load control; flush overrides everything.
  always_comb begin
    state_nxt   = state;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    case (state)
      EMPTY: if (acc) begin
        state_nxt = ONE;
        load_out  = 1'b1;
      end
      ONE: begin
        if (acc && take) begin
          load_out = 1'b1;
        end else if (acc) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (take) begin
          state_nxt = EMPTY;
        end
      end
      FULL: if (take) begin
        state_nxt   = ONE;
        skid_to_out = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) begin
      state_nxt   = EMPTY;
      load_out    = 1'b0;
      load_skid   = 1'b0;
      skid_to_out = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      skid_q      <= '0;
      count_q     <= '0;
    end else begin
      state       <= state_nxt;
      in_ready_q  <= (state_nxt != FULL);
      out_valid_q <= (state_nxt != EMPTY);
      if (load_out)         out_q  <= dec;
      else if (skid_to_out) out_q  <= skid_q;
      if (load_skid)        skid_q <= dec;
      if (acc && !flush && dec.illegal && (count_q != {CNT_W{1'b1}}))
        count_q <= count_q + CNT_W'(1);
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_control   = out_q.control;
  assign out_shamt     = out_q.shamt;
  assign out_data      = out_q.data;
  assign out_rd        = out_q.rd;
  assign out_illegal   = out_q.illegal;
  assign illegal_count = count_q;

endmodule
